// File: rtl/ets_pkg.sv
// Shared types and defaults for the ETS delay sequencer.
package ets_pkg;

  localparam int ETS_DELAY_W        = 8;
  localparam int ETS_DEFAULT_SETTLE = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } ets_seq_state_t;

endpackage

// File: rtl/ets_settle_timer.sv
// Settle countdown: counts locked cycles after a delay change; any unlocked
// cycle while enabled restarts the interval.
module ets_settle_timer #(
  parameter int SETTLE_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  input  logic lock,
  output logic zero
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load || (enable && !lock)) begin
      count <= RELOAD;
    end else if (enable && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ets_delay_sequencer.sv
// Sweeps the PLL dynamic-delay code over a latched range, settling after each
// change and requesting a fixed number of sampler captures per code.
module ets_delay_sequencer
  import ets_pkg::*;
#(
  parameter int SETTLE_CYCLES = ETS_DEFAULT_SETTLE,
  parameter int DELAY_W       = ETS_DELAY_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [DELAY_W-1:0] step_first,
  input  logic [DELAY_W-1:0] step_last,
  input  logic [DELAY_W-1:0] step_stride,
  input  logic [7:0]         caps_per_step,
  input  logic               pll_lock,
  output logic [DELAY_W-1:0] delay,
  output logic               capture_req,
  input  logic               capture_ack,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  ets_seq_state_t state_q, state_d;

  logic [DELAY_W-1:0] last_q, stride_q;
  logic [7:0]         caps_q, cap_cnt_q, cap_cnt_d;
  logic [DELAY_W-1:0] delay_d;
  logic               req_d, busy_d, done_d, aborted_d;
  logic               latch_range;
  logic               tmr_load, tmr_en, tmr_zero;
  logic               xfer, last_code;
  logic [DELAY_W:0]   next_code;

  ets_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .enable (tmr_en),
    .lock   (pll_lock),
    .zero   (tmr_zero)
  );

  assign xfer      = capture_req & capture_ack;
  // One extra bit so a stride that runs past the top of the code space ends the sweep.
  assign next_code = {1'b0, delay} + {1'b0, stride_q};
  assign last_code = (delay == last_q) || (next_code > {1'b0, last_q}) || next_code[DELAY_W];

  always_comb begin
    state_d     = state_q;
    delay_d     = delay;
    req_d       = capture_req;
    busy_d      = busy;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    cap_cnt_d   = cap_cnt_q;
    latch_range = 1'b0;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          latch_range = 1'b1;
          delay_d     = step_first;
          busy_d      = 1'b1;
          tmr_load    = 1'b1;
          state_d     = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        tmr_en = 1'b1;
        if (abort) begin
          state_d   = ST_IDLE;
          req_d     = 1'b0;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
        end else if (pll_lock && tmr_zero) begin
          state_d   = ST_CAPTURE;
          req_d     = 1'b1;
          cap_cnt_d = '0;
        end
      end

      ST_CAPTURE: begin
        if (abort) begin
          state_d   = ST_IDLE;
          req_d     = 1'b0;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
        end else if (xfer) begin
          if (cap_cnt_q == caps_q - 8'd1) begin
            req_d = 1'b0;
            if (last_code) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              delay_d  = next_code[DELAY_W-1:0];
              tmr_load = 1'b1;
              state_d  = ST_SETTLE;
            end
          end else begin
            cap_cnt_d = cap_cnt_q + 8'd1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      delay       <= '0;
      capture_req <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      cap_cnt_q   <= '0;
      last_q      <= '0;
      stride_q    <= '0;
      caps_q      <= '0;
    end else begin
      state_q     <= state_d;
      delay       <= delay_d;
      capture_req <= req_d;
      busy        <= busy_d;
      done        <= done_d;
      aborted     <= aborted_d;
      cap_cnt_q   <= cap_cnt_d;
      if (latch_range) begin
        last_q   <= step_last;
        stride_q <= (step_stride == '0) ? DELAY_W'(1) : step_stride;
        caps_q   <= (caps_per_step == 8'd0) ? 8'd1 : caps_per_step;
      end
    end
  end

endmodule

// File: tb/tb_ets_delay_sequencer.sv
// Directed bench: two sequencer instances (settle 4 and 8) share stimulus; one is observed per test.
module tb_ets_delay_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, abort, pll_lock, capture_ack;
  logic [7:0] step_first, step_last, step_stride, caps_per_step;

  logic [7:0] delay4, delay8;
  logic       req4, busy4, done4, ab4;
  logic       req8, busy8, done8, ab8;

  ets_delay_sequencer #(.SETTLE_CYCLES(4), .DELAY_W(8)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .step_first(step_first), .step_last(step_last), .step_stride(step_stride),
    .caps_per_step(caps_per_step), .pll_lock(pll_lock), .delay(delay4),
    .capture_req(req4), .capture_ack(capture_ack), .busy(busy4),
    .done(done4), .aborted(ab4)
  );

  ets_delay_sequencer #(.SETTLE_CYCLES(8), .DELAY_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .step_first(step_first), .step_last(step_last), .step_stride(step_stride),
    .caps_per_step(caps_per_step), .pll_lock(pll_lock), .delay(delay8),
    .capture_req(req8), .capture_ack(capture_ack), .busy(busy8),
    .done(done8), .aborted(ab8)
  );

  always #5 clk = ~clk;

  bit         sel;
  logic [7:0] sdelay;
  logic       sreq, sbusy, sdone, sab;
  assign sdelay = sel ? delay8 : delay4;
  assign sreq   = sel ? req8   : req4;
  assign sbusy  = sel ? busy8  : busy4;
  assign sdone  = sel ? done8  : done4;
  assign sab    = sel ? ab8    : ab4;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] codes[$];
  logic [7:0] exp_codes[$];
  int stalls, ndone, nabort;

  int   lock_lo    = 1000;
  int   lock_hi    = -1;
  int   restart_at = -1;
  bit   bp_mode    = 1'b0;
  logic ack_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always @(negedge clk) begin
    if (sreq && capture_ack) codes.push_back(sdelay);
    if (sreq && !capture_ack) stalls++;
    if (sdone) ndone++;
    if (sab) nabort++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_codes(input string tag);
    chk({tag, "_n_xfer"}, codes.size(), exp_codes.size());
    for (int i = 0; i < exp_codes.size() && i < codes.size(); i++)
      chk($sformatf("%s_code%0d", tag, i), codes[i], exp_codes[i]);
  endtask

  task automatic run_sweep(input logic [7:0] f, input logic [7:0] l, input logic [7:0] s,
                           input logic [7:0] c, input int budget, output int req_cyc);
    int cnt;
    int acnt;
    codes.delete();
    stalls = 0; ndone = 0; nabort = 0; req_cyc = 0; acnt = 0;
    step_first = f; step_last = l; step_stride = s; caps_per_step = c;
    pll_lock = 1'b1; capture_ack = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_at_start", sbusy, 1);
    chk("delay_at_start", sdelay, f);
    cnt = 1;
    while (!sdone && cnt <= budget) begin
      pll_lock = (cnt >= lock_lo && cnt <= lock_hi) ? 1'b0 : 1'b1;
      if (bp_mode) begin
        capture_ack = sreq ? ack_pat[acnt % 4] : 1'b1;
        if (sreq) acnt++;
      end else begin
        capture_ack = 1'b1;
      end
      if (cnt == restart_at) begin
        start = 1'b1; step_first = 8'h40; step_last = 8'h41;
      end else begin
        start = 1'b0;
      end
      tick();
      cnt++;
      if (sreq && req_cyc == 0) req_cyc = cnt;
    end
    start = 1'b0; pll_lock = 1'b1; capture_ack = 1'b1;
    chk("sweep_done_seen", sdone, 1);
    chk("busy_low_with_done", sbusy, 0);
    @(negedge clk);
    #1;
    chk("done_pulses", ndone, 1);
    chk("abort_pulses", nabort, 0);
  endtask

  initial begin
    int rc;
    sel = 1'b0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; pll_lock = 1'b1; capture_ack = 1'b1;
    step_first = '0; step_last = '0; step_stride = '0; caps_per_step = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_delay", delay4, 0);
    chk("rst_req", req4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_aborted", ab8, 0);

    // Nominal sweep, settle 4
    run_sweep(8'h00, 8'h03, 8'h01, 8'h02, 200, rc);
    chk("t1_first_req_cycle", rc, 5);
    exp_codes = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03};
    check_codes("t1");
    tick();
    chk("t1_done_one_cycle", done4, 0);
    chk("t1_busy_after", busy4, 0);

    // Stride overshoot
    do_reset();
    run_sweep(8'h10, 8'h1F, 8'h06, 8'h01, 200, rc);
    exp_codes = '{8'h10, 8'h16, 8'h1C};
    check_codes("t2");

    // Overflow: no wrap past 0xFF
    do_reset();
    run_sweep(8'hFE, 8'hFF, 8'h04, 8'h01, 200, rc);
    exp_codes = '{8'hFE};
    check_codes("t3");
    tick();
    chk("t3_delay_retained", delay4, 8'hFE);

    // Lock loss mid-settle, settle 8
    do_reset();
    sel = 1'b1;
    lock_lo = 4; lock_hi = 6;
    run_sweep(8'h20, 8'h20, 8'h01, 8'h01, 200, rc);
    lock_lo = 1000; lock_hi = -1;
    chk("t4_first_req_cycle", rc, 15);
    exp_codes = '{8'h20};
    check_codes("t4");
    sel = 1'b0;

    // Backpressure 1,0,0,1 per code
    do_reset();
    bp_mode = 1'b1;
    run_sweep(8'h05, 8'h06, 8'h01, 8'h02, 200, rc);
    bp_mode = 1'b0;
    exp_codes = '{8'h05, 8'h05, 8'h06, 8'h06};
    check_codes("t5");
    chk("t5_stall_cycles", stalls, 4);

    // Start while busy is ignored
    do_reset();
    restart_at = 3;
    run_sweep(8'h00, 8'h01, 8'h00, 8'h00, 200, rc);
    restart_at = -1;
    exp_codes = '{8'h00, 8'h01};
    check_codes("t7");

    // Abort in CAPTURE
    do_reset();
    step_first = 8'h00; step_last = 8'h03; step_stride = 8'h01; caps_per_step = 8'h04;
    start = 1'b1;
    tick();
    start = 1'b0;
    capture_ack = 1'b0;
    for (int i = 0; i < 20 && !req4; i++) tick();
    chk("t6_req_before_abort", req4, 1);
    abort = 1'b1; capture_ack = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_req_after_abort", req4, 0);
    chk("t6_busy_after_abort", busy4, 0);
    chk("t6_aborted_pulse", ab4, 1);
    chk("t6_no_done", done4, 0);
    tick();
    chk("t6_aborted_one_cycle", ab4, 0);

    // Start and abort together stays idle
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("t8_busy_start_abort", busy4, 0);
    tick();
    chk("t8_req_start_abort", req4, 0);

    // Reset mid-settle then a full sweep
    step_first = 8'h01; step_last = 8'h02;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t6_busy_mid_settle", busy4, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_delay", delay4, 0);
    chk("t6_rst_busy", busy4, 0);
    chk("t6_rst_req", req4, 0);
    chk("t6_rst_done", done4, 0);
    chk("t6_rst_aborted", ab4, 0);
    run_sweep(8'h01, 8'h02, 8'h01, 8'h01, 200, rc);
    exp_codes = '{8'h01, 8'h02};
    check_codes("t6_post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
